// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared definitions for the iterative RV64M multiply/divide
// unit. Holds the funct3 operation codes, the FSM state encoding, the
// iteration counts for 64-bit and word operations, and a small
// sign-extension helper.
package mul_div_unit_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned MD_ITER_64 = 64;
  localparam int unsigned MD_ITER_32 = 32;
  localparam int unsigned CNT_W      = 6;

  typedef enum logic [2:0] {
    MD_OP_MUL    = 3'd0,
    MD_OP_MULH   = 3'd1,
    MD_OP_MULHSU = 3'd2,
    MD_OP_MULHU  = 3'd3,
    MD_OP_DIV    = 3'd4,
    MD_OP_DIVU   = 3'd5,
    MD_OP_REM    = 3'd6,
    MD_OP_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_STATE_IDLE = 2'd0,
    MD_STATE_CALC = 2'd1,
    MD_STATE_FIN  = 2'd2
  } md_state_e;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV64M multiply/divide unit sitting beside the ALU.
// Radix-2 shift-add multiply and restoring divide share one 128-bit
// accumulator, one operand register and one iteration counter. Operands are
// captured (and converted to magnitudes) on the accepting edge; the result is
// registered and held until the next completion.
//
// Ports:
//   clk_in      rising-edge clock
//   rst_in      synchronous active-high reset
//   start_in    request an operation (honoured in IDLE or FIN only)
//   flush_in    abort the in-flight operation; beats start and completion
//   funct3_in   M-extension funct3 (MUL..REMU)
//   word_in     32-bit W variant
//   value1_in   rs1 operand (forwarded)
//   value2_in   rs2 operand (forwarded)
//   busy_out    high while iterating (CALC)
//   valid_out   one-cycle pulse in FIN, result_out valid
//   result_out  registered 64-bit result
module mul_div_unit
  import mul_div_unit_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        flush_in,
  input  logic [2:0]  funct3_in,
  input  logic        word_in,
  input  logic [63:0] value1_in,
  input  logic [63:0] value2_in,
  output logic        busy_out,
  output logic        valid_out,
  output logic [63:0] result_out
);

  md_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  md_op_e                op_q, op_d;
  logic                  word_q, word_d;
  logic                  neg_res_q, neg_res_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]       opnd_q, opnd_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       result_q, result_d;

  // ---------------------------------------------------------------------
  // Operand preparation (evaluated on the request inputs)
  // ---------------------------------------------------------------------
  logic        in_div, in_mulw, a_signed, b_signed;
  logic [63:0] a_ext, b_ext, a_mag, b_mag, dividend;
  logic        a_neg, b_neg;
  logic        div_zero, div_ovf, special;
  logic [63:0] special_res;
  logic        accept;

  always_comb begin
    in_div   = funct3_in[2];
    // W multiplies only need the low 32 product bits, so signedness is moot.
    in_mulw  = word_in & ~funct3_in[2];
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3_in)
      MD_OP_MULH:           begin a_signed = 1'b1; b_signed = 1'b1; end
      MD_OP_MULHSU:         a_signed = 1'b1;
      MD_OP_DIV, MD_OP_REM: begin a_signed = 1'b1; b_signed = 1'b1; end
      default:              ;
    endcase
    if (in_mulw) begin
      a_signed = 1'b0;
      b_signed = 1'b0;
    end

    if (word_in) begin
      a_ext = a_signed ? sext32(value1_in[31:0]) : {32'b0, value1_in[31:0]};
      b_ext = b_signed ? sext32(value2_in[31:0]) : {32'b0, value2_in[31:0]};
    end else begin
      a_ext = value1_in;
      b_ext = value2_in;
    end

    a_neg = a_signed & a_ext[63];
    b_neg = b_signed & b_ext[63];
    a_mag = a_neg ? (~a_ext + 64'd1) : a_ext;
    b_mag = b_neg ? (~b_ext + 64'd1) : b_ext;

    div_zero = in_div & (word_in ? (value2_in[31:0] == '0) : (value2_in == '0));
    div_ovf  = in_div & ~funct3_in[0] &
               (word_in ? ((value1_in[31:0] == 32'h8000_0000) && (value2_in[31:0] == '1))
                        : ((value1_in == 64'h8000_0000_0000_0000) && (value2_in == '1)));
    special  = div_zero | div_ovf;

    dividend = word_in ? sext32(value1_in[31:0]) : value1_in;
    if (funct3_in[1]) special_res = div_zero ? dividend : '0;
    else              special_res = div_zero ? '1 : dividend;
  end

  assign accept = start_in & ~flush_in &
                  ((state_q == MD_STATE_IDLE) || (state_q == MD_STATE_FIN));

  // ---------------------------------------------------------------------
  // One iteration step and result finalisation
  // ---------------------------------------------------------------------
  logic [64:0]  mul_sum, div_shift;
  logic [63:0]  div_diff;
  logic         div_ge;
  logic [127:0] step, mul_full;
  logic [63:0]  quo, rem, div_sel, fin_res;
  logic         last_iter;

  always_comb begin
    // Multiply: add multiplicand into the high half when the multiplier LSB
    // (in the low half) is set, then shift the whole accumulator right.
    mul_sum   = {1'b0, acc_q[127:64]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    // Divide: high half is the partial remainder, low half shifts the
    // dividend out at the top and the quotient bits in at the bottom.
    div_shift = {acc_q[127:64], acc_q[63]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    // Only used when div_ge, where the difference is below the divisor.
    div_diff  = div_shift[63:0] - opnd_q;

    if (op_q[2]) step = div_ge ? {div_diff, acc_q[62:0], 1'b1}
                               : {div_shift[63:0], acc_q[62:0], 1'b0};
    else         step = {mul_sum, acc_q[63:1]};

    mul_full = neg_res_q ? (~step + 128'd1) : step;
    quo      = neg_res_q ? (~step[63:0] + 64'd1)   : step[63:0];
    rem      = neg_rem_q ? (~step[127:64] + 64'd1) : step[127:64];
    div_sel  = op_q[1] ? rem : quo;

    // A 32-iteration multiply leaves the product at acc[127:32].
    if (op_q[2])               fin_res = word_q ? sext32(div_sel[31:0]) : div_sel;
    else if (word_q)           fin_res = sext32(step[63:32]);
    else if (op_q == MD_OP_MUL) fin_res = mul_full[63:0];
    else                       fin_res = mul_full[127:64];

    last_iter = (cnt_q == (word_q ? CNT_W'(MD_ITER_32 - 1) : CNT_W'(MD_ITER_64 - 1)));
  end

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= MD_STATE_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_STATE_IDLE, MD_STATE_FIN: begin
        if (start_in) state_d = special ? MD_STATE_FIN : MD_STATE_CALC;
        else          state_d = MD_STATE_IDLE;
      end
      MD_STATE_CALC: if (last_iter) state_d = MD_STATE_FIN;
      default:       state_d = MD_STATE_IDLE;
    endcase
    if (flush_in) state_d = MD_STATE_IDLE;
  end

  always_comb begin
    busy_out  = (state_q == MD_STATE_CALC);
    valid_out = (state_q == MD_STATE_FIN);
  end

  assign result_out = result_q;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_d     = cnt_q;
    op_d      = op_q;
    word_d    = word_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    result_d  = result_q;
    if (accept) begin
      op_d      = md_op_e'(funct3_in);
      word_d    = word_in;
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      cnt_d     = '0;
      if (in_div) begin
        opnd_d = b_mag;
        // Word divides run 32 steps, so the dividend starts at the top.
        acc_d  = {64'b0, (word_in ? {a_mag[31:0], 32'b0} : a_mag)};
      end else begin
        opnd_d = a_mag;
        acc_d  = {64'b0, b_mag};
      end
      if (special) result_d = special_res;
    end else if ((state_q == MD_STATE_CALC) && !flush_in) begin
      acc_d = step;
      cnt_d = cnt_q + 1'b1;
      if (last_iter) result_d = fin_res;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q     <= '0;
      op_q      <= MD_OP_MUL;
      word_q    <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      word_q    <= word_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

endmodule
